hc_adder_pipe: RTL and testbench

HC_ADDER_PIPE -- requirements
Module: hc_adder_pipe

---
 rtl/hc_pkg.sv | 33 +++
 rtl/hc_prefix_cell.sv | 26 ++
 rtl/hc_adder_pipe.sv | 178 +++++++++++++++++
 tb/tb_hc_adder_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc_pkg.sv
// hc_pkg: shared elaboration helpers for the Han-Carlson adder pipeline.
//   log2ceil          - ceiling log2 of a positive integer
//   hc_levels         - number of prefix levels L = log2(WIDTH) + 1
//   hc_boundary_level - prefix levels completed before register boundary s
//   hc_boundary_stage - internal stage whose register sits after level k, or -1
package hc_pkg;

    function automatic int log2ceil(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int hc_levels(input int width);
        return log2ceil(width) + 1;
    endfunction

    // Boundary s (1..stages) closes after ceil(s*levels/stages) levels, so the
    // levels are spread as evenly as possible and boundary `stages` lands on L.
    function automatic int hc_boundary_level(input int s, input int levels, input int stages);
        return (s * levels + stages - 1) / stages;
    endfunction

    // Only boundaries 1..stages-1 are internal; the last one is the output register.
    function automatic int hc_boundary_stage(input int k, input int levels, input int stages);
        for (int unsigned s = 1; s < stages; s++) begin
            if (hc_boundary_level(int'(s), levels, stages) == k) return int'(s) - 1;
        end
        return -1;
    endfunction

endpackage

// File: rtl/hc_prefix_cell.sv
// hc_prefix_cell: (g,p) prefix combine of a high group with the adjacent low group.
//   g_hi, p_hi - generate/propagate of the more significant group
//   g_lo, p_lo - generate/propagate of the less significant group
//   g_o, p_o   - combined group; p_o is 0 for a grey cell (GREY=1)
module hc_prefix_cell #(
    parameter int GREY = 0
) (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_o,
    output logic p_o
);

    assign g_o = g_hi | (p_hi & g_lo);

    if (GREY != 0) begin : grey_g
        logic unused_plo;
        assign p_o        = 1'b0;
        assign unused_plo = p_lo;
    end else begin : black_g
        assign p_o = p_hi & p_lo;
    end

endmodule

// File: rtl/hc_adder_pipe.sv
// hc_adder_pipe: pipelined Han-Carlson adder/subtractor with valid/ready flow control.
//   clk, rst_n           - rising-edge clock, synchronous active-low reset
//   in_valid, in_ready   - operand beat handshake
//   a, b, cin, sub       - operands; sub=1 computes a-b and ignores cin
//   out_valid, out_ready - result beat handshake
//   sum, cout, ovf       - result mod 2^WIDTH, carry out, signed overflow
module hc_adder_pipe
    import hc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LG = log2ceil(WIDTH);
    localparam int L  = hc_levels(WIDTH);

    // ---------------- flow control ----------------
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] ld;
    logic [STAGES:0]   rdy;

    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            rdy[STAGES-1-i] = !v[STAGES-1-i] || rdy[STAGES-i];
        end
    end

    always_comb begin
        vin    = '0;
        vin[0] = in_valid;
        for (int unsigned i = 1; i < STAGES; i++) begin
            vin[i] = v[i-1];
        end
    end

    assign ld        = rdy[STAGES-1:0] & vin;
    assign in_ready  = rst_n & rdy[0];
    assign out_valid = v[STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (rdy[i]) v[i] <= vin[i];
            end
        end
    end

    // ---------------- pre-processing ----------------
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g0;
    logic             c0;

    assign bx = sub ? ~b : b;
    assign c0 = sub | cin;
    assign p0 = a ^ bx;
    // Carry-in is folded into bit 0's generate, so after the tree G[i] is the
    // carry out of bit i including cin, and the final level needs no extra column.
    assign g0 = (a & bx) | {{(WIDTH-1){1'b0}}, p0[0] & c0};

    // ---------------- prefix levels ----------------
    // Levels 0..LG-1: Kogge-Stone on odd bits, span 2^k.
    // Level LG: grey cells fold each even bit onto its odd neighbour below.
    for (genvar k = 0; k < L; k++) begin : lvl
        localparam int BS = hc_boundary_stage(k + 1, L, STAGES);

        logic [WIDTH-1:0] gi, pi, p0i, go, po;
        logic [WIDTH-1:0] gq, pq, p0q;
        logic             ci, ami, bmi, cq, amq, bmq;

        if (k == 0) begin : src
            assign gi  = g0;
            assign pi  = p0;
            assign p0i = p0;
            assign ci  = c0;
            assign ami = a[WIDTH-1];
            assign bmi = bx[WIDTH-1];
        end else begin : src
            assign gi  = lvl[k-1].gq;
            assign pi  = lvl[k-1].pq;
            assign p0i = lvl[k-1].p0q;
            assign ci  = lvl[k-1].cq;
            assign ami = lvl[k-1].amq;
            assign bmi = lvl[k-1].bmq;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : col
            if (k < LG && (i % 2) == 1 && i >= (1 << k)) begin : black
                hc_prefix_cell #(.GREY(0)) u_cell (
                    .g_hi(gi[i]),
                    .p_hi(pi[i]),
                    .g_lo(gi[i-(1<<k)]),
                    .p_lo(pi[i-(1<<k)]),
                    .g_o (go[i]),
                    .p_o (po[i])
                );
            end else if (k == LG && (i % 2) == 0 && i >= 2) begin : grey
                hc_prefix_cell #(.GREY(1)) u_cell (
                    .g_hi(gi[i]),
                    .p_hi(pi[i]),
                    .g_lo(gi[i-1]),
                    .p_lo(pi[i-1]),
                    .g_o (go[i]),
                    .p_o (po[i])
                );
            end else begin : pass
                assign go[i] = gi[i];
                assign po[i] = pi[i];
            end
        end

        if (BS >= 0) begin : pipe_reg
            // Datapath registers are not reset; the stage valid bit qualifies them.
            always_ff @(posedge clk) begin
                if (ld[BS]) begin
                    gq  <= go;
                    pq  <= po;
                    p0q <= p0i;
                    cq  <= ci;
                    amq <= ami;
                    bmq <= bmi;
                end
            end
        end else begin : pipe_wire
            assign gq  = go;
            assign pq  = po;
            assign p0q = p0i;
            assign cq  = ci;
            assign amq = ami;
            assign bmq = bmi;
        end
    end

    // ---------------- sum and output register ----------------
    logic [WIDTH-1:0] gf;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             unused_pfin;

    assign gf          = lvl[L-1].gq;
    assign unused_pfin = ^lvl[L-1].pq;
    assign sum_d       = lvl[L-1].p0q ^ {gf[WIDTH-2:0], lvl[L-1].cq};
    assign cout_d      = gf[WIDTH-1];
    assign ovf_d       = (lvl[L-1].amq == lvl[L-1].bmq) && (sum_d[WIDTH-1] != lvl[L-1].amq);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (ld[STAGES-1]) begin
            sum  <= sum_d;
            cout <= cout_d;
            ovf  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_hc_adder_pipe.sv
module tb_hc_adder_pipe;

    localparam int NCFG  = 4;
    localparam int NRAND = 400;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        v;
    } exp_t;

    function automatic int cfg_w(input int j);
        return (j == 0) ? 8 : 16;
    endfunction

    function automatic int cfg_s(input int j);
        case (j)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 5;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;

    task automatic check(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // Arithmetic reference: unsigned result/carry and signed range check.
    function automatic exp_t ref_model(input int unsigned w, input longint unsigned av,
                                       input longint unsigned bv, input bit c, input bit s);
        longint unsigned m, t;
        longint          sa, sb, r, lim;
        exp_t            e;
        m   = (64'd1 << w) - 64'd1;
        lim = longint'(64'd1 << (w - 1));
        sa  = longint'(av);
        sb  = longint'(bv);
        if (sa >= lim) sa = sa - 2 * lim;
        if (sb >= lim) sb = sb - 2 * lim;
        if (s) begin
            t   = (av - bv) & m;
            e.c = (av >= bv);
            r   = sa - sb;
        end else begin
            t   = av + bv + 64'(c);
            e.c = (t > m);
            t   = t & m;
            r   = sa + sb + longint'(c);
        end
        e.s = t;
        e.v = (r >= lim) || (r < -lim);
        return e;
    endfunction

    for (genvar j = 0; j < NCFG; j++) begin : cfg
        localparam int W = cfg_w(j);
        localparam int S = cfg_s(j);

        logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
        logic [W-1:0] a, b, sum;
        exp_t         q[$];

        hc_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .sub      (sub),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .sum      (sum),
            .cout     (cout),
            .ovf      (ovf)
        );

        function automatic logic [W-1:0] pick_op();
            logic [W-1:0] x;
            x = W'($urandom);
            case ($urandom_range(0, 9))
                0:       x = '0;
                1:       x = '1;
                2:       x = {1'b0, {(W-1){1'b1}}};
                3:       x = {1'b1, {(W-1){1'b0}}};
                default: ;
            endcase
            return x;
        endfunction

        task automatic do_reset(input int unsigned cycles);
            @(negedge clk);
            rst_n     = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            q.delete();
            repeat (cycles) @(negedge clk);
            #1;
            check($sformatf("c%0d reset out_valid", j), longint'(out_valid), 0);
            check($sformatf("c%0d reset in_ready", j), longint'(in_ready), 0);
            check($sformatf("c%0d reset sum", j), longint'(sum), 0);
            check($sformatf("c%0d reset cout/ovf", j), longint'({cout, ovf}), 0);
            rst_n = 1'b1;
            #1;
            check($sformatf("c%0d in_ready after reset", j), longint'(in_ready), 1);
        endtask

        task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c,
                            input logic s, input bit use_exp, input exp_t ex, input bit rnd_ready);
            int unsigned t;
            bit          acc;
            exp_t        e;
            t   = 0;
            acc = 1'b0;
            e   = use_exp ? ex : ref_model(W, 64'(av), 64'(bv), c, s);
            while (!acc && t < 100) begin
                @(negedge clk);
                a        = av;
                b        = bv;
                cin      = c;
                sub      = s;
                in_valid = 1'b1;
                if (rnd_ready) out_ready = ($urandom_range(0, 99) < 70);
                #1;
                acc = in_ready;
                t++;
            end
            if (acc) q.push_back(e);
            else begin
                n_cmp++;
                n_bad++;
                $display("FAIL c%0d accept: in_ready=0 for %0d cycles, required 1", j, t);
            end
        endtask

        task automatic idle(input bit rnd_ready);
            @(negedge clk);
            in_valid = 1'b0;
            a        = W'($urandom);
            b        = W'($urandom);
            cin      = 1'($urandom_range(0, 1));
            sub      = 1'($urandom_range(0, 1));
            if (rnd_ready) out_ready = ($urandom_range(0, 99) < 70);
        endtask

        task automatic drain();
            int unsigned t;
            t = 0;
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            while (q.size() != 0 && t < 200) begin
                @(negedge clk);
                t++;
            end
            repeat (2) @(negedge clk);
            check($sformatf("c%0d beats left after drain", j), longint'(q.size()), 0);
        endtask

        task automatic latency_check();
            int unsigned lat;
            @(negedge clk);
            out_ready = 1'b1;
            send(pick_op(), pick_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'b0, '0, 1'b0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat      = 1;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("c%0d latency", j), longint'(lat), longint'(S));
            drain();
        endtask

        task automatic random_phase();
            for (int unsigned i = 0; i < NRAND; i++) begin
                if ($urandom_range(0, 99) < 65)
                    send(pick_op(), pick_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'b0, '0, 1'b1);
                else
                    idle(1'b1);
            end
            drain();
        endtask

        // Monitor: pops an expectation per output transfer and checks held outputs.
        initial begin : mon
            exp_t         e;
            logic [W-1:0] h_sum;
            logic         h_c, h_v;
            bit           holding;
            holding = 1'b0;
            forever begin
                @(negedge clk);
                #1;
                if (holding && rst_n && out_valid)
                    check($sformatf("c%0d held output", j), longint'({h_sum, h_c, h_v}),
                          longint'({sum, cout, ovf}));
                holding = 1'b0;
                if (rst_n && out_valid) begin
                    if (out_ready) begin
                        if (q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL c%0d unexpected beat: sum=0x%0h, required no beat", j, sum);
                        end else begin
                            e = q.pop_front();
                            check($sformatf("c%0d sum", j), longint'(sum), longint'(e.s));
                            check($sformatf("c%0d cout", j), longint'(cout), longint'(e.c));
                            check($sformatf("c%0d ovf", j), longint'(ovf), longint'(e.v));
                        end
                    end else begin
                        holding = 1'b1;
                        h_sum   = sum;
                        h_c     = cout;
                        h_v     = ovf;
                    end
                end
            end
        end

        if (j == 0) begin : drv_dir
            initial begin : drv
                int unsigned acc_cnt, cyc, blocked_after, stale;
                bit          blocked;
                logic [W-1:0] ta, tb;
                rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
                a = '0; b = '0; cin = 1'b0; sub = 1'b0;
                do_reset(2);
                latency_check();

                // Known-answer beats.
                @(negedge clk);
                out_ready = 1'b1;
                send(W'(8'hFF), W'(8'h01), 1'b0, 1'b0, 1'b1, '{s: 64'h00, c: 1'b1, v: 1'b0}, 1'b0);
                send(W'(8'h05), W'(8'h07), 1'b1, 1'b1, 1'b1, '{s: 64'hFE, c: 1'b0, v: 1'b0}, 1'b0);
                send(W'(8'h7F), W'(8'h01), 1'b0, 1'b0, 1'b1, '{s: 64'h80, c: 1'b0, v: 1'b1}, 1'b0);
                drain();

                // Six back-to-back beats, output stalled for the first five cycles.
                acc_cnt       = 0;
                cyc           = 0;
                blocked       = 1'b0;
                blocked_after = 99;
                while (acc_cnt < 6 && cyc < 100) begin
                    @(negedge clk);
                    out_ready = (cyc >= 5);
                    ta        = W'(acc_cnt * 37 + 5);
                    tb        = W'(acc_cnt * 11 + 3);
                    a = ta; b = tb; cin = acc_cnt[0]; sub = acc_cnt[1];
                    in_valid  = 1'b1;
                    #1;
                    if (!in_ready && !blocked) begin
                        blocked       = 1'b1;
                        blocked_after = acc_cnt;
                    end
                    if (in_ready) begin
                        q.push_back(ref_model(W, 64'(ta), 64'(tb), acc_cnt[0], acc_cnt[1]));
                        acc_cnt++;
                    end
                    cyc++;
                end
                check("c0 accepted before in_ready fell", longint'(blocked_after), 2);
                check("c0 beats accepted", longint'(acc_cnt), 6);
                drain();

                // Reset with two beats in flight.
                @(negedge clk);
                out_ready = 1'b0;
                send(W'(8'h12), W'(8'h34), 1'b0, 1'b0, 1'b0, '0, 1'b0);
                send(W'(8'h56), W'(8'h78), 1'b1, 1'b0, 1'b0, '0, 1'b0);
                do_reset(1);
                stale = 0;
                for (int unsigned i = 0; i < 10; i++) begin
                    @(negedge clk);
                    in_valid  = 1'b0;
                    out_ready = 1'b1;
                    #1;
                    if (out_valid) stale++;
                end
                check("c0 stale beats after reset", longint'(stale), 0);

                random_phase();
                repeat (3) @(negedge clk);
                done_cnt++;
            end
        end else begin : drv_rnd
            initial begin : drv
                rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
                a = '0; b = '0; cin = 1'b0; sub = 1'b0;
                do_reset(2);
                latency_check();
                random_phase();
                repeat (3) @(negedge clk);
                done_cnt++;
            end
        end
    end

    initial begin : ctl
        int unsigned t;
        t = 0;
        while (done_cnt < NCFG && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt < NCFG) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d of %0d drivers finished", done_cnt, NCFG);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
